// File: rtl/spatz_vrf_wr_arbiter_pkg.sv
// spatz_vrf_wr_arbiter_pkg: VRF write-path types shared by the write arbiter and its requesters
package spatz_vrf_wr_arbiter_pkg;
  localparam int unsigned N_IPU = 2;
  localparam int unsigned ELEN = 64;
  localparam int unsigned NrVRFBanks = 2 * N_IPU;
  typedef enum logic [1:0] {
    VFU_VD_WD   = 2'd0,
    VLSU_VD_WD  = 2'd1,
    VSLDU_VD_WD = 2'd2
  } vreg_port_wd_e;
  localparam int unsigned NrVRFWritePorts = int'(VSLDU_VD_WD) + 1;
  typedef logic [4:0] vreg_t;
  typedef logic [$clog2(NrVRFBanks)-1:0] vrf_bank_t;
  typedef struct packed {
    vreg_t     vreg;
    vrf_bank_t bank;
  } vreg_addr_t;
  typedef logic [ELEN-1:0] vreg_data_t;
  typedef logic [ELEN/8-1:0] vreg_be_t;
  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wr_req_t;
endpackage

// File: rtl/spatz_vrf_wr_bank_arb.sv
// spatz_vrf_wr_bank_arb: one-hot round-robin grant among write requesters targeting one VRF bank
module spatz_vrf_wr_bank_arb #(
  parameter int unsigned NrPorts = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NrPorts-1:0] cand_i,
  output logic [NrPorts-1:0] gnt_o
);
  localparam int unsigned PtrW = NrPorts > 1 ? $clog2(NrPorts) : 1;
  logic [PtrW-1:0] rr_q, rr_d, idx, sel;
  logic [NrPorts-1:0] rr_cand;
  logic hit;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] v);
    return v == PtrW'(NrPorts - 1) ? '0 : v + 1'b1;
  endfunction
`ifdef SPATZ_VRF_WR_VFU_PRIO_EN
  // the VFU is served outside the rotation, so it is never a round-robin candidate
  assign rr_cand = cand_i & ~NrPorts'(1);
`else
  assign rr_cand = cand_i;
`endif
  always_comb begin
    hit = 1'b0;
    sel = rr_q;
    idx = rr_q;
    for (int i = 0; i < NrPorts; i++) begin
      if (!hit && rr_cand[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
      idx = nxt(idx);
    end
    gnt_o = '0;
    gnt_o[sel] = hit;
    rr_d = hit ? nxt(sel) : rr_q;
`ifdef SPATZ_VRF_WR_VFU_PRIO_EN
    if (cand_i[0]) begin
      gnt_o = NrPorts'(1);
      rr_d = rr_q;
    end
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else rr_q <= rr_d;
  end
endmodule

// File: rtl/spatz_vrf_wr_arbiter.sv
// spatz_vrf_wr_arbiter: per-bank arbitration of VFU/VLSU/VSLDU writes onto registered VRF bank write ports
// Ports: wr_req_i/wr_addr_i/wr_data_i/wr_be_i in, wr_ack_o out (same-cycle grant);
//        vrf_we_o/vrf_waddr_o/vrf_wdata_o/vrf_wbe_o out, registered one cycle after the grant.
// Option: SPATZ_VRF_WR_VFU_PRIO_EN gives port 0 (VFU) absolute priority on its bank.
module spatz_vrf_wr_arbiter
  import spatz_vrf_wr_arbiter_pkg::*;
#(
  parameter int unsigned NrWritePorts = NrVRFWritePorts,
  parameter int unsigned NrBanks      = NrVRFBanks
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic       [NrWritePorts-1:0]  wr_req_i,
  input  vreg_addr_t [NrWritePorts-1:0]  wr_addr_i,
  input  vreg_data_t [NrWritePorts-1:0]  wr_data_i,
  input  vreg_be_t   [NrWritePorts-1:0]  wr_be_i,
  output logic       [NrWritePorts-1:0]  wr_ack_o,
  output logic       [NrBanks-1:0]       vrf_we_o,
  output vreg_t      [NrBanks-1:0]       vrf_waddr_o,
  output vreg_data_t [NrBanks-1:0]       vrf_wdata_o,
  output vreg_be_t   [NrBanks-1:0]       vrf_wbe_o
);
  vrf_wr_req_t [NrWritePorts-1:0] req;
  logic [NrBanks-1:0][NrWritePorts-1:0] cand, gnt;
  logic [NrBanks-1:0] we;
  vreg_t [NrBanks-1:0] sel_vreg;
  vreg_data_t [NrBanks-1:0] sel_data;
  vreg_be_t [NrBanks-1:0] sel_be;
  always_comb begin
    for (int p = 0; p < NrWritePorts; p++) req[p] = '{addr: wr_addr_i[p], data: wr_data_i[p], be: wr_be_i[p]};
    for (int b = 0; b < NrBanks; b++)
      for (int p = 0; p < NrWritePorts; p++) cand[b][p] = wr_req_i[p] && req[p].addr.bank == vrf_bank_t'(b);
  end
  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    spatz_vrf_wr_bank_arb #(
      .NrPorts(NrWritePorts)
    ) i_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .cand_i(cand[b]),
      .gnt_o (gnt[b])
    );
  end
  // a port decodes to exactly one bank, so OR-ing grants across banks yields at most one ack per port
  always_comb begin
    wr_ack_o = '0;
    for (int b = 0; b < NrBanks; b++) begin
      we[b] = |gnt[b];
      sel_vreg[b] = '0;
      sel_data[b] = '0;
      sel_be[b] = '0;
      for (int p = 0; p < NrWritePorts; p++) begin
        if (gnt[b][p]) begin
          wr_ack_o[p] = 1'b1;
          sel_vreg[b] = req[p].addr.vreg;
          sel_data[b] = req[p].data;
          sel_be[b] = req[p].be;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vrf_we_o <= '0;
      vrf_waddr_o <= '0;
      vrf_wdata_o <= '0;
      vrf_wbe_o <= '0;
    end else begin
      vrf_we_o <= we;
      for (int b = 0; b < NrBanks; b++) begin
        if (we[b]) begin
          vrf_waddr_o[b] <= sel_vreg[b];
          vrf_wdata_o[b] <= sel_data[b];
          vrf_wbe_o[b] <= sel_be[b];
        end
      end
    end
  end
endmodule

// File: tb/tb_spatz_vrf_wr_arbiter.sv
// tb_spatz_vrf_wr_arbiter: directed self-checking bench for the VRF write arbiter
module tb_spatz_vrf_wr_arbiter;
  import spatz_vrf_wr_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_ni;
  logic [2:0] wr_req, wr_ack;
  vreg_addr_t [2:0] wr_addr;
  vreg_data_t [2:0] wr_data;
  vreg_be_t [2:0] wr_be;
  logic [3:0] vrf_we;
  vreg_t [3:0] vrf_waddr;
  vreg_data_t [3:0] vrf_wdata;
  vreg_be_t [3:0] vrf_wbe;
  int passed = 0;
  int failed = 0;
  int total = 0;
  logic [2:0] pend = '0;
  vrf_wr_req_t [2:0] held;
  always #5 clk = ~clk;
  spatz_vrf_wr_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_be_i    (wr_be),
    .wr_ack_o   (wr_ack),
    .vrf_we_o   (vrf_we),
    .vrf_waddr_o(vrf_waddr),
    .vrf_wdata_o(vrf_wdata),
    .vrf_wbe_o  (vrf_wbe)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int p, input int bank, input int vreg, input logic [63:0] d, input logic [7:0] be);
    wr_req[p] = 1'b1;
    wr_addr[p].vreg = vreg_t'(vreg);
    wr_addr[p].bank = vrf_bank_t'(bank);
    wr_data[p] = d;
    wr_be[p] = be;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // a request that was not acked must still be raised with an unchanged payload on the next cycle
  always @(negedge clk) begin
    if (!rst_ni) pend = '0;
    else begin
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          chk("proto_hold", wr_req[p], 1);
          chk("proto_payload", {wr_addr[p], wr_data[p], wr_be[p]}, held[p]);
        end
        held[p] = '{addr: wr_addr[p], data: wr_data[p], be: wr_be[p]};
      end
      pend = wr_req & ~wr_ack;
    end
  end
  initial begin
    rst_ni = 1'b0;
    wr_req = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_be = '0;
    repeat (3) begin
      @(negedge clk);
      wr_req = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        wr_addr[p] = 7'($urandom);
        wr_data[p] = {$urandom, $urandom};
        wr_be[p] = 8'($urandom);
      end
      #1;
      chk("rst_we", vrf_we, 0);
      chk("rst_waddr", vrf_waddr, 0);
      chk("rst_wdata", |vrf_wdata, 0);
      chk("rst_wbe", vrf_wbe, 0);
    end
    @(negedge clk);
    wr_req = '0;
    #1 chk("ack_idle", wr_ack, 0);
    rst_ni = 1'b1;
    step();
    chk("we_post_release", vrf_we, 0);
    drive(1, 1, 5, 64'h0123456789ABCDEF, 8'hFF);
    #2 chk("single_ack", wr_ack, 3'b010);
    step();
    wr_req[1] = 1'b0;
    chk("single_we", vrf_we, 4'b0010);
    chk("single_waddr", vrf_waddr[1], 5);
    chk("single_wdata", vrf_wdata[1], 64'h0123456789ABCDEF);
    chk("single_wbe", vrf_wbe[1], 8'hFF);
    step();
    chk("single_we_drop", vrf_we, 0);
    chk("single_data_hold", vrf_wdata[1], 64'h0123456789ABCDEF);
    drive(0, 0, 1, 64'hA0, 8'h01);
    drive(1, 0, 2, 64'hA1, 8'h03);
    drive(2, 0, 3, 64'hA2, 8'h0F);
    #2 chk("cont_ack0", wr_ack, 3'b001);
    step();
    wr_req[0] = 1'b0;
    chk("cont_we0", vrf_we, 4'b0001);
    chk("cont_data0", vrf_wdata[0], 64'hA0);
    #2 chk("cont_ack1", wr_ack, 3'b010);
    step();
    wr_req[1] = 1'b0;
    chk("cont_we1", vrf_we, 4'b0001);
    chk("cont_data1", vrf_wdata[0], 64'hA1);
    #2 chk("cont_ack2", wr_ack, 3'b100);
    step();
    wr_req[2] = 1'b0;
    chk("cont_we2", vrf_we, 4'b0001);
    chk("cont_data2", vrf_wdata[0], 64'hA2);
    chk("cont_waddr2", vrf_waddr[0], 3);
    chk("cont_be2", vrf_wbe[0], 8'h0F);
    step();
    chk("cont_idle", vrf_we, 0);
    drive(1, 1, 6, 64'hB1, 8'h11);
    drive(2, 1, 7, 64'hB2, 8'h22);
    #2 chk("wrap_ack2", wr_ack, 3'b100);
    step();
    wr_req[2] = 1'b0;
    chk("wrap_data2", vrf_wdata[1], 64'hB2);
    #2 chk("wrap_ack1", wr_ack, 3'b010);
    step();
    wr_req[1] = 1'b0;
    chk("wrap_data1", vrf_wdata[1], 64'hB1);
    chk("wrap_we1", vrf_we, 4'b0010);
    drive(0, 0, 4, 64'hC0, 8'h01);
    drive(1, 2, 6, 64'hC1, 8'h02);
    drive(2, 3, 7, 64'hC2, 8'h04);
    #2 chk("par_ack", wr_ack, 3'b111);
    step();
    wr_req = '0;
    chk("par_we", vrf_we, 4'b1101);
    chk("par_waddr2", vrf_waddr[2], 6);
    chk("par_waddr3", vrf_waddr[3], 7);
    chk("par_wdata0", vrf_wdata[0], 64'hC0);
    chk("par_wdata3", vrf_wdata[3], 64'hC2);
    chk("par_wbe2", vrf_wbe[2], 8'h02);
    drive(0, 0, 8, 64'hD0, 8'h01);
    drive(1, 0, 9, 64'hD1, 8'h01);
    drive(2, 0, 10, 64'hD2, 8'h01);
`ifdef SPATZ_VRF_WR_VFU_PRIO_EN
    #2 chk("rstmid_ack", wr_ack, 3'b001);
`else
    #2 chk("rstmid_ack", wr_ack, 3'b010);
`endif
    step();
    chk("rstmid_we_before", vrf_we, 4'b0001);
    #2;
    rst_ni = 1'b0;
    wr_req = '0;
    #1;
    chk("rstmid_we", vrf_we, 0);
    chk("rstmid_waddr", vrf_waddr, 0);
    chk("rstmid_wdata", |vrf_wdata, 0);
    step();
    rst_ni = 1'b1;
    drive(1, 0, 11, 64'hE1, 8'h33);
    drive(2, 0, 12, 64'hE2, 8'h44);
    #2 chk("rstrel_ack1", wr_ack, 3'b010);
    step();
    wr_req[1] = 1'b0;
    chk("rstrel_we", vrf_we, 4'b0001);
    chk("rstrel_waddr", vrf_waddr[0], 11);
    #2 chk("rstrel_ack2", wr_ack, 3'b100);
    step();
    wr_req[2] = 1'b0;
    chk("rstrel_data2", vrf_wdata[0], 64'hE2);
`ifdef SPATZ_VRF_WR_VFU_PRIO_EN
    drive(0, 2, 13, 64'hF0, 8'h01);
    drive(2, 2, 14, 64'hF8, 8'h02);
    for (int c = 0; c < 3; c++) begin
      #2 chk("prio_ack0", wr_ack, 3'b001);
      step();
      chk("prio_we", vrf_we, 4'b0100);
      chk("prio_data0", vrf_wdata[2], 64'hF0 + 64'(c));
      wr_data[0] = 64'hF0 + 64'(c) + 64'h1;
    end
    wr_req[0] = 1'b0;
    #2 chk("prio_ack2", wr_ack, 3'b100);
    step();
    wr_req[2] = 1'b0;
    chk("prio_data2", vrf_wdata[2], 64'hF8);
    drive(1, 2, 15, 64'hF1, 8'h01);
    drive(2, 2, 16, 64'hF2, 8'h01);
    #2 chk("prio_rr_after", wr_ack, 3'b010);
    step();
    wr_req[1] = 1'b0;
    #2 chk("prio_rr_next", wr_ack, 3'b100);
    step();
    wr_req[2] = 1'b0;
`endif
    #2 chk("end_ack_idle", wr_ack, 0);
    step();
    chk("end_we_idle", vrf_we, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
